cache_arbiter: RTL and testbench
================================

# cache_arbiter

- Two-requester arbiter in front of the `cache` block's single command port.
- Shares that port between the instruction-fetch master (m0) and the data master (m1).
- Masters see Avalon-style ports with `waitrequest`; the cache sees single-cycle command pulses.
- At most one cache transaction is outstanding at any time. Grant is round-robin, and a timeout recovers the bus if a read is never answered.

## Interface

Parameters:

- WRITE_HOLD, 2: cycles `c_write` stays asserted per write (1..15).
- TIMEOUT, 64: cycles RD_WAIT waits for `c_readdatavalid` before aborting (2..255).

Ports:

- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- mX_address  in  20  word address, X=0,1 (same for all mX_ ports).
- mX_byteenable  in  2  bit0 low byte, bit1 high byte.
- mX_read  in  1  read request, held until accepted.
- mX_write  in  1  write request, held until accepted.
- mX_writedata  in  16  write data.
- mX_waitrequest  out  1  1 = request not accepted this cycle.
- mX_readdata  out  16  read data, valid with mX_readdatavalid.
- mX_readdatavalid  out  1  one-cycle read-return strobe.
- c_address  out  20  to cache `address`.
- c_byteenable  out  2  to cache `byteenable`.
- c_read  out  1  to cache `read`.
- c_write  out  1  to cache `write`.
- c_writedata  out  16  to cache `writedata`.
- c_readdata  in  16  from cache `readdata`.
- c_readdatavalid  in  1  from cache `readdatavalid`.
- timeout_err  out  1  one-cycle pulse when a read times out.

## Operation

States:

- IDLE: no transaction; arbitrates and accepts.
- RD_WAIT: read issued; waits for return.
- WR_HOLD: write in progress.

IDLE arbitration:

- Request from mX is `mX_read | mX_write`.
- If exactly one master requests, it wins.
- If both request, the master not granted last wins. `last_grant` resets to 1, so m0 wins the first tie.
- Winner's `mX_waitrequest` = 0 combinationally in that cycle. All other `waitrequest` = 1 in every other case.
- On acceptance, register address, byteenable, writedata and owner; update `last_grant`.
- If read and write are both asserted by one master, the write is taken and the read is dropped.

Transitions:

- Accepted read -> RD_WAIT, with `c_read` = 1 for exactly one cycle (the first RD_WAIT cycle).
- Accepted write -> WR_HOLD, with `c_write` = 1 for WRITE_HOLD cycles, then IDLE.
- RD_WAIT, `c_readdatavalid` = 1 -> `m<owner>_readdatavalid` = 1 and `m<owner>_readdata` = `c_readdata` combinationally; next state IDLE.
- RD_WAIT, TIMEOUT cycles with no valid -> `m<owner>_readdatavalid` = 1, readdata = 16'hFFFF, `timeout_err` = 1; next state IDLE.
- Timeout counter (8-bit) clears on entry to RD_WAIT and increments each RD_WAIT cycle.

Other rules:

- `c_readdatavalid` in IDLE or WR_HOLD is ignored. Non-owner `readdatavalid` is always 0.
- `c_address`, `c_byteenable`, `c_writedata` hold the latched values until the next acceptance.
- `mX_readdata` = `c_readdata` when X owns RD_WAIT, else 0.

Reset (reset = 0, any time, including mid-transaction):

- State goes to IDLE immediately.
- Outputs: `c_read`, `c_write`, `timeout_err`, `mX_readdatavalid` = 0; `mX_waitrequest` = 1 while reset is low; `c_address`/`c_byteenable`/`c_writedata` = 0.
- Any pending read is discarded, and its late `c_readdatavalid` is ignored.

## Timing

- Accept in cycle N -> `c_read`/`c_write` high from N+1 (registered).
- Read: earliest return is N+1; the next acceptance is earliest N+2, giving a 2-cycle back-to-back read throughput.
- Write: busy N+1..N+WRITE_HOLD; the next acceptance is earliest N+WRITE_HOLD+1.
- Read return is combinational from the cache to the master in the same cycle.

## Test plan

- **Single read.** m0 reads 20'h00010; cache returns 16'hBEEF two cycles after `c_read`.
  - `m0_waitrequest` = 0 in the accept cycle; one `c_read` pulse with `c_address` = 20'h00010.
  - `m0_readdatavalid` = 1 with `m0_readdata` = 16'hBEEF; m1 sees nothing.
- **Tie round-robin.** m0 and m1 both read continuously from reset.
  - Grants alternate m0, m1, m0, m1.
  - Each return goes only to its owner.
- **Write hold.** m1 writes 16'h1234 to 20'h0ABCD with byteenable 2'b10, WRITE_HOLD = 2.
  - `c_write` high exactly 2 cycles with those values.
  - m0's request waits, then is accepted the following cycle.
- **Timeout.** m0 reads and the cache never answers (TIMEOUT = 64).
  - After 64 RD_WAIT cycles: `m0_readdatavalid` = 1, `m0_readdata` = 16'hFFFF, one `timeout_err` pulse, return to IDLE.
- **Reset mid-read.** Assert reset during RD_WAIT, release, then pulse `c_readdatavalid`.
  - Outputs at reset values while low; the stray valid is not forwarded.
  - The next m0 read completes normally.
- **Illegal both.** m1 asserts read and write together.
  - Only `c_write` is issued; no `m1_readdatavalid` is ever produced.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Avalon-style master port as seen by the cache arbiter: request side driven
// by the master, waitrequest and read return driven by the arbiter.
interface cache_arbiter_if;
  logic [19:0] address;
  logic [1:0]  byteenable;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic        waitrequest;
  logic [15:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing the cache command port between the instruction
// (m0) and data (m1) masters, one outstanding transaction, read timeout.
module cache_arbiter #(
  parameter int unsigned WRITE_HOLD = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           reset,
  cache_arbiter_if.slave m0,
  cache_arbiter_if.slave m1,
  output logic [19:0]    c_address,
  output logic [1:0]     c_byteenable,
  output logic           c_read,
  output logic           c_write,
  output logic [15:0]    c_writedata,
  input  logic [15:0]    c_readdata,
  input  logic           c_readdatavalid,
  output logic           timeout_err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_HOLD} state_e;

  state_e      state_q, state_d;
  logic [19:0] addr_q;
  logic [1:0]  be_q;
  logic [15:0] wd_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [7:0]  cnt_q;
  logic [3:0]  hold_q;
  logic        c_read_q;

  logic        req0, req1;
  logic        grant_valid;
  logic        grant_sel;
  logic        sel_write;
  logic        rd_active;
  logic        timeout_hit;
  logic        ret_valid;
  logic [15:0] ret_data;

  always_comb begin
    req0        = m0.read | m0.write;
    req1        = m1.read | m1.write;
    grant_valid = (state_q == IDLE) && (req0 || req1);
    if (req0 && req1) grant_sel = ~last_grant_q;
    else              grant_sel = req1;
    sel_write   = grant_sel ? m1.write : m0.write;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = sel_write ? WR_HOLD : RD_WAIT;
      RD_WAIT: if (c_readdatavalid || timeout_hit) state_d = IDLE;
      WR_HOLD: if (hold_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      be_q         <= '0;
      wd_q         <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      hold_q       <= '0;
      c_read_q     <= 1'b0;
    end else if (grant_valid) begin
      addr_q       <= grant_sel ? m1.address    : m0.address;
      be_q         <= grant_sel ? m1.byteenable : m0.byteenable;
      wd_q         <= grant_sel ? m1.writedata  : m0.writedata;
      owner_q      <= grant_sel;
      last_grant_q <= grant_sel;
      cnt_q        <= '0;
      hold_q       <= 4'(WRITE_HOLD - 1);
      c_read_q     <= ~sel_write;
    end else begin
      c_read_q <= 1'b0;
      if (state_q == RD_WAIT) cnt_q <= cnt_q + 8'd1;
      if (state_q == WR_HOLD && hold_q != '0) hold_q <= hold_q - 4'd1;
    end
  end

  always_comb begin
    rd_active   = (state_q == RD_WAIT);
    timeout_hit = rd_active && !c_readdatavalid && (cnt_q == 8'(TIMEOUT - 1));
    ret_valid   = rd_active && (c_readdatavalid || timeout_hit);
    ret_data    = timeout_hit ? 16'hFFFF : c_readdata;

    // waitrequest must stay high throughout reset even though IDLE would grant
    m0.waitrequest   = !(reset && grant_valid && !grant_sel);
    m1.waitrequest   = !(reset && grant_valid &&  grant_sel);
    m0.readdatavalid = ret_valid && !owner_q;
    m1.readdatavalid = ret_valid &&  owner_q;
    m0.readdata      = (rd_active && !owner_q) ? ret_data : '0;
    m1.readdata      = (rd_active &&  owner_q) ? ret_data : '0;

    c_address    = addr_q;
    c_byteenable = be_q;
    c_writedata  = wd_q;
    c_read       = c_read_q;
    c_write      = (state_q == WR_HOLD);
    timeout_err  = timeout_hit;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected read returns are queued when a
// read is driven and checked when a master readdatavalid appears.
module tb_cache_arbiter;

  typedef struct {
    logic        owner;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] c_address;
  logic [1:0]  c_byteenable;
  logic        c_read, c_write, timeout_err;
  logic [15:0] c_writedata;
  logic [15:0] c_readdata = '0;
  logic        cv = 1'b0, stray_v = 1'b0, c_rdv;

  int   total = 0, bad = 0;
  exp_t exp_q[$];
  int   n_rd = 0, n_wr = 0, n_to = 0;
  int   n_v0 = 0, n_v1 = 0;

  int          lat = 2;
  logic        mute = 1'b0;
  logic        use_fixed = 1'b0;
  logic [15:0] fixed_data = 16'hBEEF;

  assign c_rdv = cv | stray_v;

  cache_arbiter_if m0_if ();
  cache_arbiter_if m1_if ();

  cache_arbiter #(.WRITE_HOLD(2), .TIMEOUT(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .m0              (m0_if),
    .m1              (m1_if),
    .c_address       (c_address),
    .c_byteenable    (c_byteenable),
    .c_read          (c_read),
    .c_write         (c_write),
    .c_writedata     (c_writedata),
    .c_readdata      (c_readdata),
    .c_readdatavalid (c_rdv),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cdata(input logic [19:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    m0_if.read = 0; m0_if.write = 0; m0_if.address = '0; m0_if.byteenable = 2'b11; m0_if.writedata = '0;
    m1_if.read = 0; m1_if.write = 0; m1_if.address = '0; m1_if.byteenable = 2'b11; m1_if.writedata = '0;
  endtask

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; n_to = 0; n_v0 = 0; n_v1 = 0;
  endtask

  task automatic apply_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
    step();
  endtask

  // Cache model: answers each c_read pulse after lat cycles unless muted
  initial begin
    int          pend;
    logic [15:0] resp;
    pend = 0;
    resp = '0;
    forever begin
      @(posedge clk);
      #1;
      cv = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cv = 1'b1;
          c_readdata = resp;
        end
      end
      if (c_read && !mute) begin
        pend = lat;
        resp = use_fixed ? fixed_data : cdata(c_address);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (c_read) n_rd++;
      if (c_write) n_wr++;
      if (timeout_err) n_to++;
      if (m0_if.readdatavalid) n_v0++;
      if (m1_if.readdatavalid) n_v1++;
      if (m0_if.readdatavalid || m1_if.readdatavalid) begin
        if (m0_if.readdatavalid && m1_if.readdatavalid)
          chk("rdv_both", 1, 0);
        if (exp_q.size() == 0) begin
          chk("rdv_unexpected", {m1_if.readdatavalid, m0_if.readdatavalid}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_owner", m1_if.readdatavalid, e.owner);
          chk("rd_data", m1_if.readdatavalid ? m1_if.readdata : m0_if.readdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n0, n1, k;
    clear_masters();
    m0_if.read = 1;
    m0_if.address = 20'h00777;

    // reset state, with a live request that must not be granted
    repeat (2) @(negedge clk);
    chk("rst_wait0", m0_if.waitrequest, 1);
    chk("rst_wait1", m1_if.waitrequest, 1);
    chk("rst_cread", c_read, 0);
    chk("rst_cwrite", c_write, 0);
    chk("rst_caddr", c_address, 0);
    chk("rst_rdv", {m1_if.readdatavalid, m0_if.readdatavalid}, 0);
    m0_if.read = 0;
    step();
    reset = 1;
    step();

    // single read
    clear_counts();
    use_fixed = 1; lat = 2;
    m0_if.address = 20'h00010; m0_if.read = 1;
    exp_q.push_back('{owner: 1'b0, data: 16'hBEEF});
    @(negedge clk);
    chk("t1_wait0", m0_if.waitrequest, 0);
    chk("t1_wait1", m1_if.waitrequest, 1);
    step();
    m0_if.read = 0;
    @(negedge clk);
    chk("t1_cread", c_read, 1);
    chk("t1_caddr", c_address, 20'h00010);
    wait_drain("t1_drain");
    chk("t1_nrd", n_rd, 1);
    chk("t1_m1_quiet", n_v1, 0);
    use_fixed = 0;

    // tie round-robin from reset
    apply_reset();
    clear_counts();
    lat = 1;
    exp_q.push_back('{owner: 1'b0, data: cdata(20'h00100)});
    exp_q.push_back('{owner: 1'b1, data: cdata(20'h00200)});
    exp_q.push_back('{owner: 1'b0, data: cdata(20'h00101)});
    exp_q.push_back('{owner: 1'b1, data: cdata(20'h00201)});
    m0_if.address = 20'h00100; m0_if.read = 1;
    m1_if.address = 20'h00200; m1_if.read = 1;
    g = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      @(negedge clk);
      if (!m0_if.waitrequest || !m1_if.waitrequest) begin
        chk("tie_one_grant", !m0_if.waitrequest && !m1_if.waitrequest, 0);
        chk("tie_order", m0_if.waitrequest ? 1 : 0, 32'(g % 2));
        if (!m0_if.waitrequest) n0++; else n1++;
        g++;
      end
      step();
      if (n0 >= 1) m0_if.address = 20'h00101;
      if (n1 >= 1) m1_if.address = 20'h00201;
      if (n0 == 2) m0_if.read = 0;
      if (n1 == 2) m1_if.read = 0;
    end
    chk("tie_grants", g, 4);
    wait_drain("tie_drain");

    // write hold with m0 waiting behind it
    clear_counts();
    lat = 2;
    m1_if.address = 20'h0ABCD; m1_if.byteenable = 2'b10;
    m1_if.writedata = 16'h1234; m1_if.write = 1;
    @(negedge clk);
    chk("wr_wait1", m1_if.waitrequest, 0);
    step();
    m1_if.write = 0;
    m0_if.address = 20'h00020; m0_if.read = 1;
    exp_q.push_back('{owner: 1'b0, data: cdata(20'h00020)});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("wr_cwrite", c_write, 1);
      chk("wr_caddr", c_address, 20'h0ABCD);
      chk("wr_cbe", c_byteenable, 2'b10);
      chk("wr_cwd", c_writedata, 16'h1234);
      chk("wr_m0_held", m0_if.waitrequest, 1);
      step();
    end
    @(negedge clk);
    chk("wr_cwrite_end", c_write, 0);
    chk("wr_m0_accept", m0_if.waitrequest, 0);
    step();
    m0_if.read = 0;
    wait_drain("wr_drain");
    chk("wr_nwr", n_wr, 2);

    // read timeout
    clear_counts();
    mute = 1;
    m0_if.address = 20'h00030; m0_if.read = 1;
    exp_q.push_back('{owner: 1'b0, data: 16'hFFFF});
    step();
    m0_if.read = 0;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      k++;
      if (timeout_err) break;
    end
    chk("to_cycles", k, 64);
    chk("to_rdv", m0_if.readdatavalid, 1);
    chk("to_data", m0_if.readdata, 16'hFFFF);
    step();
    @(negedge clk);
    chk("to_pulse_end", timeout_err, 0);
    wait_drain("to_drain");
    chk("to_npulse", n_to, 1);
    mute = 0;

    // reset during RD_WAIT, then a stray late valid
    clear_counts();
    mute = 1;
    m0_if.address = 20'h00040; m0_if.read = 1;
    step();
    m0_if.read = 0;
    step();
    step();
    reset = 0;
    m0_if.read = 1;
    @(negedge clk);
    chk("mr_wait0", m0_if.waitrequest, 1);
    chk("mr_cread", c_read, 0);
    chk("mr_caddr", c_address, 0);
    chk("mr_rdv", m0_if.readdatavalid, 0);
    chk("mr_to", timeout_err, 0);
    step();
    m0_if.read = 0;
    reset = 1;
    step();
    stray_v = 1; c_readdata = 16'h0BAD;
    @(negedge clk);
    chk("mr_stray", m0_if.readdatavalid, 0);
    step();
    stray_v = 0;
    mute = 0;
    m0_if.address = 20'h00050; m0_if.read = 1;
    exp_q.push_back('{owner: 1'b0, data: cdata(20'h00050)});
    step();
    m0_if.read = 0;
    wait_drain("mr_drain");

    // read and write together: write wins, no read return
    clear_counts();
    m1_if.address = 20'h00060; m1_if.writedata = 16'h5555; m1_if.byteenable = 2'b11;
    m1_if.read = 1; m1_if.write = 1;
    @(negedge clk);
    chk("rw_wait1", m1_if.waitrequest, 0);
    step();
    m1_if.read = 0; m1_if.write = 0;
    repeat (8) step();
    chk("rw_nwr", n_wr, 2);
    chk("rw_nrd", n_rd, 0);
    chk("rw_nv1", n_v1, 0);

    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
